// File: rtl/branch_resolve_queue_if.sv
// Interface bundle for branch_resolve_queue.
// Purpose: groups the prediction-issue handshake, the resolve inputs and all
// predictor-update/status outputs of the queue.
//   master : the predictor/pipeline side (drives pred_*, resolve_*).
//   slave  : the queue itself (drives pred_ready, upd_*, mispredict, mis_ghr,
//            occupancy, underflow, resolved_cnt, mispred_cnt).
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int GHR_W = 3,
  parameter int CNT_W = 8
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             pred_valid;
  logic             pred_bit;
  logic [GHR_W-1:0] pred_ghr;
  logic             pred_ready;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             upd_en;
  logic             upd_bit;
  logic             mispredict;
  logic [GHR_W-1:0] mis_ghr;
  logic [OCC_W-1:0] occupancy;
  logic             underflow;
  logic [CNT_W-1:0] resolved_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output pred_valid, pred_bit, pred_ghr, resolve_valid, resolve_taken,
    input  pred_ready, upd_en, upd_bit, mispredict, mis_ghr, occupancy,
           underflow, resolved_cnt, mispred_cnt
  );

  modport slave (
    input  pred_valid, pred_bit, pred_ghr, resolve_valid, resolve_taken,
    output pred_ready, upd_en, upd_bit, mispredict, mis_ghr, occupancy,
           underflow, resolved_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// Purpose: in-order FIFO of issued branch predictions (direction + GHR
// snapshot). When the oldest branch resolves, the head is popped and
// compared with the actual outcome; one cycle later the predictor update
// strobe (upd_en/upd_bit) is driven and mispredictions are flagged with the
// GHR snapshot they were made with. Saturating resolved/mispredict counters.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : branch_resolve_queue_if.slave (prediction push, resolve,
//            update/mispredict outputs, occupancy, underflow, counters)
// Optional feature: define BRQ_FLUSH_ON_MISPREDICT_EN to discard all younger
// (wrong-path) entries, and any same-cycle push, on a mispredicting pop.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int GHR_W = 3,
  parameter int CNT_W = 8
) (
  input logic                    clk,
  input logic                    reset,
  branch_resolve_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DEPTH-1:0] r_mem_bit;
  logic [GHR_W-1:0] r_mem_ghr [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [OCC_W-1:0] r_occ;
  logic             r_upd_en;
  logic             r_upd_bit;
  logic             r_mispredict;
  logic [GHR_W-1:0] r_mis_ghr;
  logic             r_underflow;
  logic [CNT_W-1:0] r_resolved_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_mis;
  logic w_flush;
  logic w_push_eff;

  always_comb begin
    w_ready = (r_occ != OCC_W'(DEPTH));
    w_push  = bus.pred_valid && w_ready;
    // Pop decision uses the pre-push occupancy: no same-cycle bypass.
    w_pop   = bus.resolve_valid && (r_occ != '0);
    w_mis   = w_pop && (r_mem_bit[r_head] != bus.resolve_taken);
`ifdef BRQ_FLUSH_ON_MISPREDICT_EN
    w_flush = w_mis;
`else
    w_flush = 1'b0;
`endif
    w_push_eff = w_push && !w_flush;
  end

  // Storage needs no reset: occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push_eff) begin
      r_mem_bit[r_tail] <= bus.pred_bit;
      r_mem_ghr[r_tail] <= bus.pred_ghr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (w_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push_eff) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)      r_head <= r_head + PTR_W'(1);
      case ({w_push_eff, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_upd_en       <= 1'b0;
      r_upd_bit      <= 1'b0;
      r_mispredict   <= 1'b0;
      r_mis_ghr      <= '0;
      r_underflow    <= 1'b0;
      r_resolved_cnt <= '0;
      r_mispred_cnt  <= '0;
    end else begin
      r_upd_en     <= w_pop;
      r_mispredict <= w_mis;
      if (w_pop) r_upd_bit <= bus.resolve_taken;
      if (w_mis) r_mis_ghr <= r_mem_ghr[r_head];
      if (bus.resolve_valid && (r_occ == '0)) r_underflow <= 1'b1;
      if (w_pop && (r_resolved_cnt != '1))
        r_resolved_cnt <= r_resolved_cnt + CNT_W'(1);
      if (w_mis && (r_mispred_cnt != '1))
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end

  assign bus.pred_ready   = w_ready;
  assign bus.upd_en       = r_upd_en;
  assign bus.upd_bit      = r_upd_bit;
  assign bus.mispredict   = r_mispredict;
  assign bus.mis_ghr      = r_mis_ghr;
  assign bus.occupancy    = r_occ;
  assign bus.underflow    = r_underflow;
  assign bus.resolved_cnt = r_resolved_cnt;
  assign bus.mispred_cnt  = r_mispred_cnt;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Testbench for branch_resolve_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model and a scoreboard of
// expected predictor updates consumed by an independent monitor.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int GHR_W = 3;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  branch_resolve_queue_if #(.DEPTH(DEPTH), .GHR_W(GHR_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .GHR_W(GHR_W), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             b;
    logic [GHR_W-1:0] g;
  } ent_t;

  typedef struct {
    bit             upd_bit;
    bit             mis;
    bit [GHR_W-1:0] ghr;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int   m_rc;
  int   m_mc;
  bit   m_uf;
  bit [GHR_W-1:0] m_misghr;
  int   n_pops;
  int   n_pulses;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    sb.delete();
    m_rc = 0;
    m_mc = 0;
    m_uf = 1'b0;
    m_misghr = '0;
  endtask

  // One clock cycle: check state left by the previous edge, drive inputs,
  // and advance the reference model to what the coming edge should produce.
  task automatic do_cycle(input bit pv, input bit pb, input bit [GHR_W-1:0] pg,
                          input bit rv, input bit rt);
    bit   full;
    bit   mis;
    ent_t e;
    @(negedge clk);
    chk("occupancy", int'(bus.occupancy), mq.size());
    chk("pred_ready", int'(bus.pred_ready), (mq.size() != DEPTH) ? 1 : 0);
    chk("underflow", int'(bus.underflow), int'(m_uf));
    chk("resolved_cnt", int'(bus.resolved_cnt), m_rc);
    chk("mispred_cnt", int'(bus.mispred_cnt), m_mc);
    bus.pred_valid    = pv;
    bus.pred_bit      = pb;
    bus.pred_ghr      = pg;
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    full = (mq.size() == DEPTH);
    mis  = 1'b0;
    if (rv) begin
      if (mq.size() > 0) begin
        e   = mq.pop_front();
        mis = (e.b != rt);
        m_rc = (m_rc < CMAX) ? m_rc + 1 : CMAX;
        if (mis) begin
          m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
          m_misghr = e.g;
        end
        sb.push_back('{upd_bit: rt, mis: mis, ghr: m_misghr});
        n_pops++;
      end else begin
        m_uf = 1'b1;
      end
    end
`ifdef BRQ_FLUSH_ON_MISPREDICT_EN
    if (mis) mq.delete();
    else if (pv && !full) mq.push_back('{b: pb, g: pg});
`else
    if (pv && !full) mq.push_back('{b: pb, g: pg});
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    bus.pred_valid    = 1'b0;
    bus.pred_bit      = 1'b0;
    bus.pred_ghr      = '0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    reset = 1'b0;
    model_clear();
    #1;
    chk("rst_occupancy", int'(bus.occupancy), 0);
    chk("rst_upd_en", int'(bus.upd_en), 0);
    chk("rst_upd_bit", int'(bus.upd_bit), 0);
    chk("rst_mispredict", int'(bus.mispredict), 0);
    chk("rst_mis_ghr", int'(bus.mis_ghr), 0);
    chk("rst_underflow", int'(bus.underflow), 0);
    chk("rst_resolved_cnt", int'(bus.resolved_cnt), 0);
    chk("rst_mispred_cnt", int'(bus.mispred_cnt), 0);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  // Monitor: consumes one expected update per observed upd_en pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.upd_en) begin
        n_pulses++;
        if (sb.size() == 0) begin
          chk("unexpected_upd_en", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("upd_bit", int'(bus.upd_bit), int'(e.upd_bit));
          chk("mispredict", int'(bus.mispredict), int'(e.mis));
          chk("mis_ghr", int'(bus.mis_ghr), int'(e.ghr));
        end
      end else if (bus.mispredict) begin
        chk("mispredict_without_upd_en", 1, 0);
      end
    end
  end

  initial begin
    n_tests = 0; n_fail = 0; n_pops = 0; n_pulses = 0;
    model_clear();
    reset = 1'b0;
    bus.pred_valid    = 1'b0;
    bus.pred_bit      = 1'b0;
    bus.pred_ghr      = '0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset state after release
    @(negedge clk);
    chk("init_pred_ready", int'(bus.pred_ready), 1);
    chk("init_occupancy", int'(bus.occupancy), 0);
    chk("init_upd_en", int'(bus.upd_en), 0);
    chk("init_mispredict", int'(bus.mispredict), 0);
    chk("init_underflow", int'(bus.underflow), 0);
    chk("init_resolved_cnt", int'(bus.resolved_cnt), 0);

    // Correct prediction, then misprediction
    do_cycle(1'b1, 1'b1, 3'b101, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(1);
    chk("flow_resolved_cnt", int'(bus.resolved_cnt), 1);
    chk("flow_mispred_cnt", int'(bus.mispred_cnt), 0);
    do_cycle(1'b1, 1'b0, 3'b011, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(1);
    chk("mis_ghr_011", int'(bus.mis_ghr), 3);
    chk("mis_mispred_cnt", int'(bus.mispred_cnt), 1);

    // Fill, overflow push, push+pop while full, wrap-around pairs
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b1, 3'(i), 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
    chk("full_pred_ready", int'(bus.pred_ready), 0);
    do_cycle(1'b1, 1'b1, 3'b110, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("full_pushpop_occ", int'(bus.occupancy), DEPTH - 1);
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b1, 3'(i + 2), 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Mispredict with younger entries present
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 3'(i + 4), 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    @(posedge clk); #1;
`ifdef BRQ_FLUSH_ON_MISPREDICT_EN
    chk("flush_occ", int'(bus.occupancy), 0);
`else
    chk("flush_occ", int'(bus.occupancy), 2);
`endif
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Underflow is sticky
    idle(1);
    do_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(3);
    chk("underflow_sticky", int'(bus.underflow), 1);

    // Reset mid-operation discards entries and clears underflow
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'(i), 3'(i), 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    apply_reset();
    idle(2);

    // Random traffic (long enough for both counters to reach saturation)
    for (int i = 0; i < 3000; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 6),
               1'($urandom_range(0, 1)));
    end
    idle(3);
    @(negedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("update_pulse_count", n_pulses, n_pops);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits directly downstream of the branch predictor and feeds its update interface.
- Buffers each issued prediction, together with the GHR snapshot it was made with, in an in-order FIFO until the branch resolves.
- On resolution it compares the oldest prediction with the actual outcome, drives the predictor's update_en/in_bit pair and flags mispredictions.
- Keeps saturating resolved and mispredict counters.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- GHR_W, 3, width of the GHR snapshot stored per entry.
- CNT_W, 8, width of the resolved and mispredict counters.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- pred_valid  input  1  a prediction is issued this cycle.
- pred_bit  input  1  predicted direction (1 = taken).
- pred_ghr  input  GHR_W  GHR value used for the prediction.
- pred_ready  output  1  queue can accept a prediction (not full).
- resolve_valid  input  1  the oldest outstanding branch resolves this cycle.
- resolve_taken  input  1  actual direction.
- upd_en  output  1  one-cycle update strobe to the predictor.
- upd_bit  output  1  actual outcome to the predictor.
- mispredict  output  1  one-cycle pulse; the resolved prediction was wrong.
- mis_ghr  output  GHR_W  GHR snapshot of the mispredicted branch.
- occupancy  output  log2(DEPTH)+1  valid entries.
- underflow  output  1  sticky flag: a resolve arrived with the queue empty.
- resolved_cnt  output  CNT_W  saturating count of resolutions.
- mispred_cnt  output  CNT_W  saturating count of mispredictions.

Behaviour:
- Reset (async, reset=0): pointers and occupancy 0; upd_en, upd_bit, mispredict, mis_ghr, underflow and both counters all 0; pred_ready=1 once reset is released.
- pred_ready = (occupancy != DEPTH), combinational.
- Push: pred_valid && pred_ready stores {pred_bit, pred_ghr} at the tail. A push while full is dropped, with no state change.
- Pop: resolve_valid && occupancy != 0 at the start of the cycle pops the head.
  - There is no same-cycle bypass: a resolve cannot match a prediction pushed in the same cycle.
- Resolve while empty: ignored, and underflow is set to 1 and held until reset.
- Outputs registered, latency 1 cycle after a pop:
  - upd_en=1 and upd_bit=resolve_taken.
  - mispredict = (head.pred_bit != resolve_taken).
  - mis_ghr = head.ghr when mispredicting; otherwise it holds its previous value.
  - upd_en and mispredict are 0 in all other cycles.
- Simultaneous push and pop (no flush): both take effect and occupancy is unchanged. This is legal when full, because pred_ready is computed from the pre-pop occupancy, so the push is refused.
- Pointers wrap modulo DEPTH; occupancy is held separately to distinguish full from empty.
- Counters:
  - resolved_cnt increments on each pop.
  - mispred_cnt increments on each mispredicting pop.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-operation: all entries are discarded immediately and there is no pending update.

Optional Feature:
- Macro BRQ_FLUSH_ON_MISPREDICT_EN.
- Defined: on a mispredicting pop, all younger entries are wrong-path entries and are discarded in the same edge.
  - Occupancy becomes 0 and both pointers reset to 0.
  - A push in that same cycle is also dropped.
  - From the next cycle the queue is empty and pred_ready=1.
- Undefined: a mispredict only pops the head; younger entries are kept and resolved normally.

Test Plan:
- Reset behaviour: release reset with no stimulus -> pred_ready=1, occupancy=0, all outputs 0.
- Correct-prediction flow: push pred_bit=1/ghr=3'b101, then resolve_taken=1 -> on the next cycle upd_en=1, upd_bit=1, mispredict=0; resolved_cnt=1, mispred_cnt=0.
- Misprediction: push pred_bit=0/ghr=3'b011, then resolve_taken=1 -> upd_en=1, upd_bit=1, mispredict=1, mis_ghr=3'b011, mispred_cnt=1.
- Full queue and wrap-around (DEPTH=4):
  - 4 pushes -> pred_ready=0.
  - A 5th push -> dropped.
  - Then push+resolve in the same cycle -> the push is refused and occupancy=3.
  - Continue cycling 10 push/resolve pairs -> FIFO order is preserved across the wrap.
- Underflow: resolve_valid=1 while empty -> no upd_en, underflow=1, which stays 1 until reset.
- Flush (macro defined): push 3 entries; resolve the head mispredicting -> occupancy=0 on the next cycle and a later resolve sets underflow. With the macro undefined, the same stimulus gives occupancy=2.
